// File: rtl/edge_toggle_gen.sv
// Toggle-mask pattern source. Queued {toggle, hold} commands are applied one at a
// time to a registered level vector, with an idle gap of 'hold' cycles after each.
//
// state   | meaning
// IDLE    | pop the FIFO head (if any) and apply its mask this edge
// HOLD    | count down the hold time of the last applied mask, no pops
module edge_toggle_gen #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  toggle,
    input  logic [HOLD_W-1:0] hold,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + HOLD_W;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;

    logic              full;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  head_toggle;
    logic [HOLD_W-1:0] head_hold;

    // Ready depends only on registered occupancy, so a same-edge pop never frees a slot early.
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_IDLE) && (count_q != '0);

    assign {head_toggle, head_hold} = mem_q[rd_ptr_q];

    assign out  = out_q;
    assign busy = (state_q == ST_HOLD) || (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {toggle, hold};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    out_d = out_q ^ head_toggle;
                    cnt_d = head_hold;
                    if (head_hold != '0) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q <= HOLD_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // Storage needs no reset: entries are only read while occupancy says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_edge_toggle_gen.sv
// Directed bench for edge_toggle_gen: latency, hold timing, full-FIFO backpressure,
// reset flush, and an any-edge detector sequence check on random traffic.
module tb_edge_toggle_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] toggle;
    logic [7:0] hold;
    logic [7:0] out;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       mon_en = 1'b0;
    logic [7:0] last_out = 8'h00;
    logic [7:0] exp_q[$];

    edge_toggle_gen #(.WIDTH(8), .DEPTH(4), .HOLD_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .toggle   (toggle),
        .hold     (hold),
        .out      (out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Any-edge detector model: every nonzero change of out must match the next queued toggle.
    always @(negedge clk) begin
        logic [7:0] d;
        d = out ^ last_out;
        if (mon_en && d != 8'h00) begin
            if (exp_q.size() == 0) check_val("mon_extra_edge", int'(d), 0);
            else                   check_val("mon_edge_seq", int'(d), int'(exp_q.pop_front()));
        end
        last_out = out;
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_cmd(input logic [7:0] t, input logic [7:0] h, output int acc_cyc);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        toggle   = t;
        hold     = h;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_val("push_timeout", 0, 1);
        @(posedge clk);
        if (mon_en && t != 8'h00) exp_q.push_back(t);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        exp_q.delete();
        reset    = 1'b1;
        in_valid = 1'b0;
        toggle   = 8'h00;
        hold     = 8'h00;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, int'(busy), 0);
    endtask

    task automatic wait_out(input string tag, input logic [7:0] v, input int max_cyc, output int at_cyc);
        int n;
        n = 0;
        while (out !== v && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, int'(out), int'(v));
        at_cyc = cyc;
    endtask

    initial begin
        int a, b, c;
        logic [7:0] t, h;

        // 1: reset state and single-command latency
        do_reset();
        check_val("rst_out", int'(out), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        push_cmd(8'h01, 8'h00, a);
        check_val("t1_out_after_P", int'(out), 0);
        check_val("t1_busy_after_P", int'(busy), 1);
        @(negedge clk);
        check_val("t1_out_after_P1", int'(out), 8'h01);
        @(negedge clk);
        check_val("t1_busy_after_P2", int'(busy), 0);

        // 2: back-to-back hold=0 masks
        do_reset();
        push_cmd(8'h06, 8'h00, a);
        push_cmd(8'h06, 8'h00, a);
        check_val("t2_out_first", int'(out), 8'h06);
        @(negedge clk);
        check_val("t2_out_second", int'(out), 8'h00);

        // 3: hold=3 blocks the next pop until E+4
        do_reset();
        push_cmd(8'hFF, 8'h03, a);
        push_cmd(8'h0F, 8'h00, a);
        check_val("t3_out_E", int'(out), 8'hFF);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_val($sformatf("t3_out_E%0d", i), int'(out), 8'hFF);
            check_val($sformatf("t3_busy_E%0d", i), int'(busy), 1);
        end
        @(negedge clk);
        check_val("t3_out_E4", int'(out), 8'hF0);

        // 4: fill to full with hold=5; sixth command waits for the slot freed at P+7
        do_reset();
        mon_en = 1'b1;
        push_cmd(8'h01, 8'h05, a);
        push_cmd(8'h02, 8'h05, b);
        push_cmd(8'h04, 8'h05, b);
        push_cmd(8'h08, 8'h05, b);
        push_cmd(8'h10, 8'h05, b);
        check_val("t4_in_ready_full", int'(in_ready), 0);
        check_val("t4_busy_full", int'(busy), 1);
        push_cmd(8'h20, 8'h05, c);
        check_val("t4_sixth_accept_cyc", c - a, 8);
        wait_idle("t4_drain", 200);
        check_val("t4_final_out", int'(out), 8'h3F);
        check_val("t4_exp_left", exp_q.size(), 0);

        // 5: reset during HOLD with three commands queued
        do_reset();
        push_cmd(8'h01, 8'h05, a);
        push_cmd(8'h02, 8'h05, a);
        push_cmd(8'h04, 8'h05, a);
        push_cmd(8'h08, 8'h05, a);
        check_val("t5_out_before_rst", int'(out), 8'h01);
        reset = 1'b1;
        @(negedge clk);
        check_val("t5_rst_out", int'(out), 0);
        check_val("t5_rst_busy", int'(busy), 0);
        check_val("t5_rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_val("t5_out_stays", int'(out), 0);
        check_val("t5_busy_stays", int'(busy), 0);

        // 7: toggle=0 pure delay, then maximum hold
        do_reset();
        push_cmd(8'h00, 8'h02, a);
        push_cmd(8'h01, 8'h00, b);
        wait_out("t7_delay_out", 8'h01, 20, c);
        check_val("t7_delay_cyc", c - a, 4);
        push_cmd(8'h80, 8'hFF, a);
        push_cmd(8'h02, 8'h00, b);
        wait_out("t7_maxhold_first", 8'h81, 20, b);
        wait_out("t7_maxhold_second", 8'h83, 400, c);
        check_val("t7_maxhold_gap", c - b, 256);

        // 6: random traffic through the any-edge detector model
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            t = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            h = 8'($urandom_range(0, 3));
            push_cmd(t, h, a);
        end
        wait_idle("t6_drain", 100);
        check_val("t6_exp_left", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
